// File: rtl/snake_anim_if.sv
// Control and frame bundle for snake_anim: the board control drives the master side,
// the animation engine implements the slave side.
interface snake_anim_if #(
  parameter int unsigned REGLEN = 60,
  parameter int unsigned LENW   = 6,
  parameter int unsigned DIVW   = 8
);
  logic              en;
  logic              restart;
  logic [DIVW-1:0]   step_lim;
  logic [1:0]        mode;
  logic [LENW-1:0]   snk_len;
  logic [REGLEN-1:0] frame;
  logic              step_o;
  logic              dir_o;
  logic              grown;

  modport master (
    output en, restart, step_lim, mode, snk_len,
    input  frame, step_o, dir_o, grown
  );

  modport slave (
    input  en, restart, step_lim, mode, snk_len,
    output frame, step_o, dir_o, grown
  );
endinterface

// File: rtl/snake_anim.sv
// LED snake animation engine: prescaled stepping, growth to a runtime length, rotate/ping/blink.
// Define SNAKE_ANIM_PING_EN to build the ping-pong mode; otherwise mode 2 acts as rotate-left.
module snake_anim #(
  parameter int unsigned REGLEN = 60,
  parameter int unsigned LENW   = 6,
  parameter int unsigned DIVW   = 8
) (
  input logic         clk,
  input logic         reset,
  snake_anim_if.slave bus
);

  localparam int unsigned GW = $clog2(REGLEN + 1);
  localparam int unsigned CW = (LENW > GW) ? LENW : GW;

  typedef enum logic [1:0] {
    ModeRotL  = 2'd0,
    ModeRotR  = 2'd1,
    ModePing  = 2'd2,
    ModeBlink = 2'd3
  } mode_e;

  mode_e             mode;
  logic [DIVW-1:0]   cnt_q, cnt_d;
  logic [REGLEN-1:0] frame_q, frame_d;
  logic [CW-1:0]     g_q, g_d;
  logic [CW-1:0]     len_cap, len_eff, len_ext;
  logic              step_q, step_fire, fill;

  assign mode    = mode_e'(bus.mode);
  assign len_ext = CW'(bus.snk_len);

`ifdef SNAKE_ANIM_PING_EN
  logic dir_q, dir_d;
  logic ping_mode;

  assign ping_mode = (mode == ModePing);
  // One slot stays dark in ping mode so the bounce is visible.
  assign len_cap   = ping_mode ? CW'(REGLEN - 1) : CW'(REGLEN);
`else
  assign len_cap   = CW'(REGLEN);
`endif

  assign len_eff   = (len_ext > len_cap) ? len_cap : len_ext;
  assign fill      = (g_q < len_eff);
  assign step_fire = bus.en && (cnt_q >= bus.step_lim) && !bus.restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      frame_q <= '0;
      g_q     <= '0;
      step_q  <= 1'b0;
`ifdef SNAKE_ANIM_PING_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      g_q     <= g_d;
      step_q  <= step_fire;
`ifdef SNAKE_ANIM_PING_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.restart) begin
      cnt_d = '0;
    end else if (bus.en) begin
      // >= keeps the prescaler bounded when step_lim drops below the running count.
      cnt_d = (cnt_q >= bus.step_lim) ? '0 : cnt_q + DIVW'(1);
    end
  end

  always_comb begin
    frame_d = frame_q;
    g_d     = g_q;
`ifdef SNAKE_ANIM_PING_EN
    dir_d   = dir_q;
`endif
    if (bus.restart) begin
      frame_d = '0;
      g_d     = '0;
`ifdef SNAKE_ANIM_PING_EN
      dir_d   = 1'b0;
`endif
    end else if (step_fire) begin
      if (mode != ModeBlink && fill) begin
        g_d = g_q + CW'(1);
      end
`ifdef SNAKE_ANIM_PING_EN
      if (!ping_mode) begin
        dir_d = 1'b0;
      end
`endif
      if (mode == ModeBlink) begin
        frame_d = (frame_q == '0) ? '1 : '0;
`ifdef SNAKE_ANIM_PING_EN
      end else if (ping_mode) begin
        if (!dir_q) begin
          if (frame_q[REGLEN-1]) begin
            dir_d   = 1'b1;
            frame_d = {1'b0, frame_q[REGLEN-1:1]};
          end else begin
            frame_d = {frame_q[REGLEN-2:0], fill};
          end
        end else if (frame_q[0]) begin
          dir_d   = 1'b0;
          frame_d = {frame_q[REGLEN-2:0], fill};
        end else begin
          frame_d = {1'b0, frame_q[REGLEN-1:1]};
        end
`endif
      end else if (mode == ModeRotR) begin
        frame_d = {fill | frame_q[0], frame_q[REGLEN-1:1]};
      end else begin
        frame_d = {frame_q[REGLEN-2:0], fill | frame_q[REGLEN-1]};
      end
    end
  end

  always_comb begin
    bus.frame  = frame_q;
    bus.step_o = step_q;
    bus.grown  = (g_q == len_eff);
`ifdef SNAKE_ANIM_PING_EN
    bus.dir_o  = dir_q;
`else
    bus.dir_o  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_snake_anim.sv
// Bench for snake_anim: spec vector table, hand-written corner sequences and a randomized
// run against an arithmetic reference model.
module tb_snake_anim;

  localparam int unsigned REGLEN = 8;
  localparam int unsigned LENW   = 4;
  localparam int unsigned DIVW   = 4;
`ifdef SNAKE_ANIM_PING_EN
  localparam bit PING_EN = 1'b1;
`else
  localparam bit PING_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  snake_anim_if #(.REGLEN(REGLEN), .LENW(LENW), .DIVW(DIVW)) bus ();

  snake_anim #(.REGLEN(REGLEN), .LENW(LENW), .DIVW(DIVW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: frame held as an integer, updated from the mode rules each edge.
  int m_frame, m_g, m_cnt;
  bit m_dir, m_step;

  function automatic int len_eff_m(input int md, input int sl);
    int cap;
    cap = (PING_EN && md == 2) ? REGLEN - 1 : REGLEN;
    return (sl < cap) ? sl : cap;
  endfunction

  task automatic model_reset();
    m_frame = 0; m_g = 0; m_cnt = 0; m_dir = 0; m_step = 0;
  endtask

  task automatic model_edge();
    int  md, le, inj, top;
    bit  fill, step;
    md  = int'(bus.mode);
    top = 1 << (REGLEN - 1);
    if (bus.restart) begin
      model_reset();
      return;
    end
    step = bus.en && (m_cnt >= int'(bus.step_lim));
    if (bus.en) m_cnt = step ? 0 : m_cnt + 1;
    m_step = step;
    if (!step) return;
    le   = len_eff_m(md, int'(bus.snk_len));
    fill = (m_g < le);
    if (md == 3) begin
      m_frame = (m_frame == 0) ? (1 << REGLEN) - 1 : 0;
      m_dir   = 0;
    end else begin
      if (fill) m_g++;
      if (md == 2 && PING_EN) begin
        if (!m_dir) begin
          if ((m_frame & top) != 0) begin
            m_dir = 1; m_frame = m_frame / 2;
          end else begin
            m_frame = ((m_frame * 2) % (1 << REGLEN)) + int'(fill);
          end
        end else if ((m_frame % 2) == 1) begin
          m_dir = 0; m_frame = ((m_frame * 2) % (1 << REGLEN)) + int'(fill);
        end else begin
          m_frame = m_frame / 2;
        end
      end else if (md == 1) begin
        inj     = fill ? 1 : m_frame % 2;
        m_frame = m_frame / 2 + inj * top;
        m_dir   = 0;
      end else begin
        inj     = fill ? 1 : ((m_frame & top) != 0);
        m_frame = ((m_frame * 2) % (1 << REGLEN)) + inj;
        m_dir   = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d_frame", cyc), bus.frame, m_frame);
    check($sformatf("rnd%0d_step", cyc), bus.step_o, m_step);
    check($sformatf("rnd%0d_dir", cyc), bus.dir_o, m_dir);
    check($sformatf("rnd%0d_grown", cyc), bus.grown,
          (m_g == len_eff_m(int'(bus.mode), int'(bus.snk_len))));
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [3:0] len;
    int         steps;
    logic [7:0] frame;
    logic       grown;
    logic       dir;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back(vec_t'{2'd0, 4'd3, 1,  8'h01, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2'd0, 4'd3, 2,  8'h03, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2'd0, 4'd3, 3,  8'h07, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd0, 4'd3, 4,  8'h0E, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd0, 4'd3, 5,  8'h1C, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd0, 4'd3, 11, 8'h07, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd1, 4'd2, 1,  8'h80, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2'd1, 4'd2, 2,  8'hC0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd1, 4'd2, 3,  8'h60, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd1, 4'd2, 4,  8'h30, 1'b1, 1'b0});
`ifdef SNAKE_ANIM_PING_EN
    vecs.push_back(vec_t'{2'd2, 4'd3, 3,  8'h07, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd2, 4'd3, 8,  8'hE0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd2, 4'd3, 9,  8'h70, 1'b1, 1'b1});
    vecs.push_back(vec_t'{2'd2, 4'd3, 13, 8'h07, 1'b1, 1'b1});
    vecs.push_back(vec_t'{2'd2, 4'd3, 14, 8'h0E, 1'b1, 1'b0});
`else
    vecs.push_back(vec_t'{2'd2, 4'd3, 3,  8'h07, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd2, 4'd3, 5,  8'h1C, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd2, 4'd3, 11, 8'h07, 1'b1, 1'b0});
    vecs.push_back(vec_t'{2'd2, 4'd3, 13, 8'h1C, 1'b1, 1'b0});
`endif
    vecs.push_back(vec_t'{2'd3, 4'd3, 1,  8'hFF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2'd3, 4'd3, 2,  8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2'd0, 4'd0, 5,  8'h00, 1'b1, 1'b0});

    bus.en = 1'b1; bus.restart = 1'b0; bus.step_lim = '0; bus.mode = '0; bus.snk_len = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_frame", bus.frame, 0);
    check("rst_step", bus.step_o, 0);
    check("rst_dir", bus.dir_o, 0);
    check("rst_grown_len0", bus.grown, 1);
    bus.snk_len = 4'd3;
    #1;
    check("rst_grown_len3", bus.grown, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus.mode = vecs[i].mode; bus.snk_len = vecs[i].len;
      bus.step_lim = '0; bus.en = 1'b1; bus.restart = 1'b1;
      tick();
      bus.restart = 1'b0;
      repeat (vecs[i].steps) tick();
      check($sformatf("vec%0d_frame", i), bus.frame, vecs[i].frame);
      check($sformatf("vec%0d_grown", i), bus.grown, vecs[i].grown);
      check($sformatf("vec%0d_dir", i), bus.dir_o, vecs[i].dir);
      check($sformatf("vec%0d_step", i), bus.step_o, 1);
    end

    // Prescaler period and en freeze.
    bus.mode = 2'd0; bus.snk_len = 4'd3; bus.step_lim = 4'd3; bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("period_clk%0d", i), bus.step_o, (i % 4 == 0));
    end
    tick();
    check("period_gap", bus.step_o, 0);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("freeze%0d_step", i), bus.step_o, 0);
      check($sformatf("freeze%0d_frame", i), bus.frame, 8'h07);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("resume_clk%0d", i), bus.step_o, (i == 3));
    end
    check("resume_frame", bus.frame, 8'h0E);

    // Raising the target length mid-run resumes growth.
    bus.mode = 2'd0; bus.snk_len = 4'd2; bus.step_lim = '0; bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    repeat (3) tick();
    check("grow2_frame", bus.frame, 8'h06);
    bus.snk_len = 4'd4;
    repeat (2) tick();
    check("grow4_frame", bus.frame, 8'h1B);
    check("grow4_grown", bus.grown, 1);
    tick();
    check("grow4_rot", bus.frame, 8'h36);

    // Synchronous restart mid-run.
    bus.mode = 2'd2; bus.snk_len = 4'd3; bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    repeat (10) tick();
    check("pre_restart_dir", bus.dir_o, PING_EN ? 1 : 0);
    bus.restart = 1'b1;
    tick();
    check("restart_frame", bus.frame, 0);
    check("restart_dir", bus.dir_o, 0);
    check("restart_step", bus.step_o, 0);
    check("restart_grown", bus.grown, 0);
    bus.restart = 1'b0;
    tick();
    check("restart_regrow", bus.frame, 8'h01);

    // Asynchronous reset between edges.
    bus.mode = 2'd0; bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    repeat (4) tick();
    check("pre_areset_frame", bus.frame, 8'h0E);
    #2;
    reset = 1'b1;
    #1;
    check("areset_frame", bus.frame, 0);
    check("areset_step", bus.step_o, 0);
    check("areset_dir", bus.dir_o, 0);
    check("areset_grown", bus.grown, 0);
    model_reset();
    #2;
    reset = 1'b0;
    tick();
    check("post_areset_frame", bus.frame, 8'h01);

    // Randomized run against the model.
    bus.snk_len = 4'd9;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0)  bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.step_lim = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) bus.snk_len = 4'($urandom_range(0, 15));
      bus.en      = ($urandom_range(0, 7) != 0);
      bus.restart = ($urandom_range(0, 49) == 0);
      tick();
      check_model(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
